// File: rtl/bch_pkg.sv
// Shared constants for the BCH(63,56) sequencer: code geometry, generator, FSM states.
package bch_pkg;
   localparam int N = 63;
   localparam int K = 56;
   localparam int M = 7;

   // g(x) = x^7 + x^6 + x^2 + 1 = (x^6 + x + 1)(x + 1); the x^7 term is implicit
   localparam logic [M-1:0] BCH_GPOLY = 7'h45;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_RUN    = 3'd2,
      ST_SEARCH = 3'd3,
      ST_FIX    = 3'd4,
      ST_OUT    = 3'd5
   } bch_st_e;
endpackage

// File: rtl/bch_dec_seq_if.sv
// Bundle of the input, syndrome-engine and output handshakes of the BCH sequencer.
interface bch_dec_seq_if;
   logic                 in_valid;
   logic                 in_ready;
   logic [bch_pkg::N-1:0] in_data;
   logic                 syn_clr_n;
   logic                 syn_en;
   logic [bch_pkg::N-1:0] syn_data;
   logic                 syn_done;
   logic [bch_pkg::M-1:0] syn_value;
   logic                 out_valid;
   logic                 out_ready;
   logic [bch_pkg::K-1:0] out_data;
   logic                 out_err;
   logic                 out_fail;

   modport master (
      output in_valid, in_data, syn_done, syn_value, out_ready,
      input  in_ready, syn_clr_n, syn_en, syn_data, out_valid, out_data, out_err, out_fail
   );

   modport slave (
      input  in_valid, in_data, syn_done, syn_value, out_ready,
      output in_ready, syn_clr_n, syn_en, syn_data, out_valid, out_data, out_err, out_fail
   );
endinterface

// File: rtl/bch_gf_mulx.sv
// One Chien-style step: s(x) * x mod g(x).
module bch_gf_mulx
   import bch_pkg::*;
(
   input  logic [M-1:0] i_s,
   output logic [M-1:0] o_s
);
   assign o_s = {i_s[M-2:0], 1'b0} ^ (i_s[M-1] ? BCH_GPOLY : '0);
endmodule

// File: rtl/bch_dec_seq.sv
// Single-error BCH(63,56) decode sequencer driving an external syndrome engine.
// Define BCH_SEQ_TIMEOUT_EN to add a TIMEOUT_CYC watchdog on the engine wait.
module bch_dec_seq
   import bch_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic         clk,
   input  logic         rst_n,
   bch_dec_seq_if.slave bus
);
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
      $error("TIMEOUT_CYC must fit the 10-bit watchdog");
   end

   bch_st_e      r_state;
   logic [N-1:0] r_cw;
   logic [M-1:0] r_s;
   logic [5:0]   r_k;
   logic         r_err;
   logic         r_fail;
   logic [M-1:0] w_s_nxt;
   logic [5:0]   w_k_inc;
   logic [5:0]   w_p;
   logic         w_to_hit;

   bch_gf_mulx u_mulx (.i_s(r_s), .o_s(w_s_nxt));

   assign w_k_inc = r_k + 6'd1;
   // s*x^k == 1 means the error sits at x^(63-k); k=0 maps to position 0
   assign w_p     = (r_k == 6'd0) ? 6'd0 : 6'd63 - r_k;

`ifdef BCH_SEQ_TIMEOUT_EN
   logic [9:0] r_to;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_to <= '0;
      else if (r_state == ST_RUN)  r_to <= r_to + 10'd1;
      else                         r_to <= '0;
   end

   assign w_to_hit = (r_to == 10'(TIMEOUT_CYC - 1));
`else
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cw    <= '0;
         r_s     <= '0;
         r_k     <= '0;
         r_err   <= 1'b0;
         r_fail  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.in_valid) begin
               r_cw    <= bus.in_data;
               r_state <= ST_CLR;
            end
            ST_CLR: r_state <= ST_RUN;
            ST_RUN: begin
               if (bus.syn_done) begin
                  r_s     <= bus.syn_value;
                  r_k     <= '0;
                  r_state <= (bus.syn_value == '0) ? ST_OUT : ST_SEARCH;
               end else if (w_to_hit) begin
                  r_fail  <= 1'b1;
                  r_state <= ST_OUT;
               end
            end
            ST_SEARCH: begin
               if (r_s == 7'b0000001) begin
                  r_state <= ST_FIX;
               end else begin
                  r_s <= w_s_nxt;
                  r_k <= w_k_inc;
                  // all 63 powers of x tried without a hit: more than one error
                  if (w_k_inc == 6'd63) begin
                     r_fail  <= 1'b1;
                     r_state <= ST_OUT;
                  end
               end
            end
            ST_FIX: begin
               r_cw    <= r_cw ^ (63'(1) << w_p);
               r_err   <= 1'b1;
               r_state <= ST_OUT;
            end
            ST_OUT: if (bus.out_ready) begin
               r_err   <= 1'b0;
               r_fail  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.syn_clr_n = (r_state != ST_CLR);
   assign bus.syn_en    = (r_state == ST_RUN);
   assign bus.syn_data  = r_cw;
   assign bus.out_valid = (r_state == ST_OUT);
   assign bus.out_data  = r_cw[N-1:N-K];
   assign bus.out_err   = r_err;
   assign bus.out_fail  = r_fail;
endmodule

// File: tb/tb_bch_dec_seq.sv
// Random and directed decode tests for bch_dec_seq against a brute-force BCH reference.
module tb_bch_dec_seq;
   localparam int         TO    = 40;
   localparam logic [7:0] GFULL = 8'hC5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bch_dec_seq_if bus();
   bch_dec_seq #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // polynomial long division of w(x) by g(x)
   function automatic logic [6:0] rem7(input logic [62:0] w);
      logic [62:0] t;
      t = w;
      for (int i = 62; i >= 7; i--)
         if (t[i]) t = t ^ (63'(GFULL) << (i - 7));
      return t[6:0];
   endfunction

   function automatic logic [62:0] enc(input logic [55:0] m);
      logic [62:0] w;
      w = {m, 7'b0};
      return w | 63'(rem7(w));
   endfunction

   // syndrome engine model: done after eng_lat enabled cycles, held until the next clear
   int         eng_lat = 2;
   bit         eng_hang = 1'b0;
   bit         ovr_en = 1'b0;
   logic [6:0] ovr_val = 7'd0;
   int         eng_cnt;
   logic       eng_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_cnt  <= 0;
         eng_done <= 1'b0;
      end else if (!bus.syn_clr_n) begin
         eng_cnt  <= 0;
         eng_done <= 1'b0;
      end else if (bus.syn_en && !eng_done && !eng_hang) begin
         eng_cnt <= eng_cnt + 1;
         if (eng_cnt + 1 >= eng_lat) eng_done <= 1'b1;
      end
   end

   assign bus.syn_done  = eng_done;
   assign bus.syn_value = ovr_en ? ovr_val : rem7(bus.syn_data);

   task automatic run_word(input string tag, input logic [62:0] rx, input int lat,
                           input bit stall, input bit junk);
      logic [6:0]  s;
      logic [62:0] fx;
      logic [55:0] e_data;
      logic        e_err, e_fail;
      int          e_lat, cyc;
      bit          bad;

      s      = ovr_en ? ovr_val : rem7(rx);
      e_data = rx[62:7];
      e_err  = 1'b0;
      e_fail = 1'b0;
      e_lat  = -1;
      if (eng_hang) begin
         e_fail = 1'b1;
         e_lat  = 2 + TO;
      end else if (s == 7'd0) begin
         e_lat = 3 + lat;
      end else begin
         e_fail = 1'b1;
         for (int p = 0; p < 63; p++)
            if (rem7(63'(1) << p) == s) begin
               fx     = rx ^ (63'(1) << p);
               e_data = fx[62:7];
               e_err  = 1'b1;
               e_fail = 1'b0;
            end
         if (e_fail) e_lat = 3 + lat + 63;
      end

      @(negedge clk);
      chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
      eng_lat      = lat;
      bus.in_valid = 1'b1;
      bus.in_data  = rx;
      @(posedge clk); #1;
      if (junk) bus.in_data = ~rx;
      else      bus.in_valid = 1'b0;

      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.out_valid && cyc < 300);
      bus.in_valid = 1'b0;

      chk({tag, "_ovld"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_data"}, 64'(bus.out_data), 64'(e_data));
      chk({tag, "_flags"}, 64'({bus.out_err, bus.out_fail}), 64'({e_err, e_fail}));
      if (e_lat >= 0) chk({tag, "_lat"}, 64'(cyc), 64'(e_lat));

      if (stall) begin
         bad = 1'b0;
         repeat (10) begin
            @(negedge clk);
            if (bus.out_data !== e_data || bus.out_err !== e_err || bus.out_fail !== e_fail ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
         end
         chk({tag, "_stall"}, 64'(bad), 64'd0);
      end

      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_ret"}, 64'({bus.in_ready, bus.out_valid, bus.out_err, bus.out_fail}), 64'd8);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [55:0] m;
      logic [62:0] cw;
      logic [63:0] r64;
      int          ty, p1, p2;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #1;
      chk("reset", 64'({bus.in_ready, bus.syn_en, bus.syn_clr_n, bus.out_valid,
                        bus.out_err, bus.out_fail}), 64'b101000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      m = 56'hA5_1234_5678_9ABC;
      run_word("zero", enc(m), 2, 1'b0, 1'b0);
      run_word("bit40", enc(m) ^ (63'(1) << 40), 3, 1'b0, 1'b0);
      run_word("bit0", enc(m) ^ 63'(1), 1, 1'b0, 1'b0);
      run_word("par3", enc(m) ^ (63'(1) << 3), 2, 1'b0, 1'b0);
      run_word("bit62", enc(~m) ^ (63'(1) << 62), 4, 1'b0, 1'b0);
      run_word("dbl", enc(m) ^ (63'(1) << 10) ^ (63'(1) << 50), 2, 1'b0, 1'b0);

      ovr_en  = 1'b1;
      ovr_val = 7'b0000011;
      run_word("unreach", enc(m), 2, 1'b0, 1'b0);
      ovr_en  = 1'b0;

      run_word("stall", enc(56'h0F_F00F_F00F_F00F) ^ (63'(1) << 20), 2, 1'b1, 1'b1);

      // reset while the search is at k=12 (bit 40 needs k=23)
      eng_lat = 3;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = enc(m) ^ (63'(1) << 40);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3 + 3 + 12) @(negedge clk);
      chk("pre_rst_ovld", 64'(bus.out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst", 64'({bus.in_ready, bus.syn_en, bus.out_valid, bus.syn_clr_n,
                          bus.out_err, bus.out_fail}), 64'b100100);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_word("post_rst", enc(m) ^ (63'(1) << 33), 2, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r64 = {$urandom(), $urandom()};
         m   = r64[55:0];
         cw  = enc(m);
         ty  = $urandom_range(0, 2);
         p1  = $urandom_range(0, 62);
         p2  = (p1 + $urandom_range(1, 62)) % 63;
         if (ty >= 1) cw = cw ^ (63'(1) << p1);
         if (ty == 2) cw = cw ^ (63'(1) << p2);
         run_word("rnd", cw, $urandom_range(1, 8), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0));
      end

`ifdef BCH_SEQ_TIMEOUT_EN
      eng_hang = 1'b1;
      run_word("timeout", enc(m) ^ (63'(1) << 12), 2, 1'b0, 1'b0);
      eng_hang = 1'b0;
      run_word("after_to", enc(m) ^ (63'(1) << 12), 2, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
